// File: rtl/p_mat_seq.sv
// Symmetric matrix load/dump sequencer: streams the upper triangle into two-port
// storage (with mirrored writes) and streams the full matrix back out row-major.
module p_mat_seq #(
  parameter int SPECTRAL_BANDS = 103,
  parameter int I_WIDTH        = 4,
  parameter int F_WIDTH        = 28,
  localparam int W             = I_WIDTH + F_WIDTH,
  localparam int AW            = $clog2(SPECTRAL_BANDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_op,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] row_1,
  output logic [AW-1:0] col_1,
  output logic [AW-1:0] row_2,
  output logic [AW-1:0] col_2,
  output logic          wr_en_1,
  output logic          wr_en_2,
  output logic [W-1:0]  in_1,
  output logic [W-1:0]  in_2,
  input  logic [W-1:0]  out_1,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;

  localparam logic [AW-1:0] LAST = AW'(SPECTRAL_BANDS - 1);

  state_t        state_q;
  logic [AW-1:0] row_q, col_q;
  logic [AW-1:0] row_1_q, col_1_q, row_2_q, col_2_q;
  logic [W-1:0]  in_1_q, in_2_q;
  logic          wr_en_1_q, wr_en_2_q, done_q;
  logic          infl_q;
  logic [W-1:0]  fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q;

  logic xfer, pop, rd_issue, flush_empty;

  assign s_ready = (state_q == WRITE);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = fifo_q[rd_ptr_q];
  assign row_1   = row_1_q;
  assign col_1   = col_1_q;
  assign row_2   = row_2_q;
  assign col_2   = col_2_q;
  assign in_1    = in_1_q;
  assign in_2    = in_2_q;
  assign wr_en_1 = wr_en_1_q;
  assign wr_en_2 = wr_en_2_q;

  assign xfer = s_valid && s_ready;
  assign pop  = m_valid && m_ready;
  // A same-cycle pop frees a slot, which is what lets the stream run at one beat per cycle.
  assign rd_issue = (state_q == READ) &&
                    (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign flush_empty = !infl_q && ((cnt_q == 2'd0) || (cnt_q == 2'd1 && pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_1_q   <= '0;
      col_1_q   <= '0;
      row_2_q   <= '0;
      col_2_q   <= '0;
      in_1_q    <= '0;
      in_2_q    <= '0;
      wr_en_1_q <= 1'b0;
      wr_en_2_q <= 1'b0;
      done_q    <= 1'b0;
      infl_q    <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_en_1_q <= 1'b0;
      wr_en_2_q <= 1'b0;
      row_2_q   <= '0;
      col_2_q   <= '0;
      in_1_q    <= '0;
      in_2_q    <= '0;
      infl_q    <= rd_issue;
      if (infl_q) begin
        fifo_q[wr_ptr_q] <= out_1;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          row_1_q <= '0;
          col_1_q <= '0;
          if (cmd_start) state_q <= cmd_op ? READ : WRITE;
        end
        WRITE: begin
          row_1_q <= '0;
          col_1_q <= '0;
          if (xfer) begin
            wr_en_1_q <= 1'b1;
            row_1_q   <= row_q;
            col_1_q   <= col_q;
            in_1_q    <= s_data;
            wr_en_2_q <= (row_q != col_q);
            row_2_q   <= col_q;
            col_2_q   <= row_q;
            in_2_q    <= s_data;
            if (col_q == LAST) begin
              if (row_q == LAST) begin
                row_q   <= '0;
                col_q   <= '0;
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
                col_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        READ: begin
          // The port-1 address registers double as the read position counters.
          if (rd_issue) begin
            if (col_1_q == LAST) begin
              col_1_q <= '0;
              if (row_1_q == LAST) begin
                row_1_q <= '0;
                state_q <= FLUSH;
              end else begin
                row_1_q <= row_1_q + 1'b1;
              end
            end else begin
              col_1_q <= col_1_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_empty) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
